// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES byte-substitution tables and lookup helper.
// Used by the SubBytes pipeline, the encrypt/decrypt round datapaths and the
// key expansion.
//   byte_t       8-bit AES byte
//   SBOX         forward S-box, indexed by the byte value ({row, column})
//   INV_SBOX     inverse S-box, same indexing
//   sbox_lookup  forward (inv = 0) or inverse (inv = 1) substitution of one byte
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int LANES_MAX  = 16;
  localparam int STAGES_MAX = 4;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t sbox_lookup(byte_t b, logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// sbox_lane
// Combinational single-byte AES substitution with direction select.
//   in_byte   byte to substitute
//   inv       0 = forward S-box, 1 = inverse S-box
//   out_byte  substituted byte
module sbox_lane
  import aes_pkg::*;
(
  input  byte_t in_byte,
  input  logic  inv,
  output byte_t out_byte
);

  assign out_byte = sbox_lookup(in_byte, inv);

endmodule

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe
// Pipelined AES SubBytes stage with valid/ready handshake. All LANES bytes of a
// word are substituted in parallel; the direction travels with each word.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data, in_inv     input word (lane i = bits [8i+7:8i]) and its direction
//   out_valid/out_ready output handshake
//   out_data, out_inv   substituted word and the direction it was processed with
//   busy                any stage holds a word
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic               busy
);

  localparam int W = 8 * LANES;

  if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
    $error("sub_bytes_pipe: LANES must be 1..16");
  end
  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sub_bytes_pipe: STAGES must be 1..4");
  end

  logic [W-1:0]      lut_data;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] inv_q;
  logic [W-1:0]      dat [STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .in_byte  (in_data[8*i +: 8]),
      .inv      (in_inv),
      .out_byte (lut_data[8*i +: 8])
    );
  end

  // A stage can move when out_ready is high or any stage from it to the output
  // is empty; written flat so the stall chain has no self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&vld[STAGES-1:k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      inv_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld[0]   <= in_valid;
        dat[0]   <= lut_data;
        inv_q[0] <= in_inv;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld[k]   <= vld[k-1];
          dat[k]   <= dat[k-1];
          inv_q[k] <= inv_q[k-1];
        end
      end
    end
  end

  // Held low during reset even though the empty pipe could otherwise accept.
  assign in_ready  = rst_n & adv[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign busy      = |vld;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
module tb_sub_bytes_pipe;

  localparam int LANES  = 16;
  localparam int STAGES = 2;
  localparam int W      = 8 * LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_inv, busy;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  sub_bytes_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inv   (out_inv),
    .busy      (busy)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         inv;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n_pop = 0;
  int   stalls = 0;
  int   occ = 0;
  bit   acc_s = 1'b0;
  bit   emit_s = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   hold_prev = 1'b0;
  logic [W-1:0] prev_d;
  logic         prev_inv;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  // Independent S-box model: GF(2^8) multiplicative inverse plus affine map.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] x, s;
    for (int a = 0; a < 256; a++) begin
      x = 8'h00;
      for (int c = 1; c < 256; c++)
        if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) x = 8'(c);
      s = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [W-1:0] model(logic [W-1:0] d, logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every output transfer, stall stability, busy.
  always @(negedge clk) begin
    exp_t e;
    acc_s  = in_valid & in_ready;
    emit_s = out_valid & out_ready;
    if (rst_n) begin
      check("busy_vs_occupancy", W'(busy), W'(occ != 0));
      if (hold_prev) begin
        check("stall_valid_held", W'(out_valid), W'(1));
        check("stall_data_held", out_data, prev_d);
        check("stall_inv_held", W'(out_inv), W'(prev_inv));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_inv", W'(out_inv), W'(e.inv));
          n_pop++;
        end
      end
      hold_prev = out_valid & ~out_ready;
      prev_d    = out_data;
      prev_inv  = out_inv;
    end else begin
      hold_prev = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ = 0;
    else        occ = occ + int'(acc_s) - int'(emit_s);
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: model(d, inv), inv: inv});
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1);
    check("drain_empty", W'(sb.size()), W'(0));
  endtask

  localparam logic [W-1:0] V1_IN  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [W-1:0] V1_OUT = 128'h76ABD7FE2B670130C56F6BF27B777C63;
  localparam logic [W-1:0] V2_IN  = 128'hD7FE2B670130C56F6BF27B7716ED7C63;
  localparam logic [W-1:0] V2_OUT = 128'h0D0C0B0A0908070605040302FF530100;

  initial begin
    logic [W-1:0] d;
    int pop0;
    int stall0;
    build_tables();

    // Reset values
    idle(3);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_inv", W'(out_inv), W'(0));
    check("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", W'(in_ready), W'(1));
    idle(1);

    // Forward vector, latency of STAGES-1 cycles after acceptance
    send(V1_IN, 1'b0);
    @(negedge clk);
    check("latency_not_early", W'(out_valid), W'(0));
    idle(1);
    @(negedge clk);
    check("fwd_valid", W'(out_valid), W'(1));
    check("fwd_data", out_data, V1_OUT);
    check("fwd_inv", W'(out_inv), W'(0));
    idle(1);

    // Inverse vector
    send(V2_IN, 1'b1);
    idle(1);
    @(negedge clk);
    check("inv_valid", W'(out_valid), W'(1));
    check("inv_data", out_data, V2_OUT);
    check("inv_inv", W'(out_inv), W'(1));
    idle(1);
    drain();

    // Exhaustive, back-to-back in both directions
    pop0 = n_pop;
    stalls = 0;
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 256; j++) begin
        for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(j + 17 * i);
        send(d, 1'(m));
      end
    end
    drain();
    check("exhaustive_no_stall", W'(stalls), W'(0));
    check("exhaustive_count", W'(n_pop - pop0), W'(512));

    // Backpressure: fill, simultaneous accept+emit, single-cycle pulses
    pop0 = n_pop;
    out_ready = 1'b0;
    send(128'h00112233445566778899AABBCCDDEEFF, 1'b0);
    send(128'hFFEEDDCCBBAA99887766554433221100, 1'b1);
    @(negedge clk);
    check("full_in_ready", W'(in_ready), W'(0));
    check("full_out_valid", W'(out_valid), W'(1));
    idle(4);
    out_ready = 1'b1;
    stall0 = stalls;
    send(128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    out_ready = 1'b0;
    check("full_accept_no_stall", W'(stalls - stall0), W'(0));
    @(negedge clk);
    check("full_after_swap_busy", W'(busy), W'(1));
    check("full_after_swap_in_ready", W'(in_ready), W'(0));
    check("full_after_swap_pops", W'(n_pop - pop0), W'(1));
    for (int p = 0; p < 2; p++) begin
      idle(1);
      out_ready = 1'b1;
      @(negedge clk);
      check("pulse_in_ready", W'(in_ready), W'(1));
      idle(1);
      out_ready = 1'b0;
      idle(2);
      check("pulse_pops", W'(n_pop - pop0), W'(2 + p));
    end
    @(negedge clk);
    check("bp_drained_busy", W'(busy), W'(0));
    check("bp_drained_sb", W'(sb.size()), W'(0));
    idle(1);

    // Alternating direction, random gaps and random out_ready
    pop0 = n_pop;
    rdy_rand = 1'b1;
    for (int w = 0; w < 20; w++) begin
      idle($urandom_range(0, 3));
      send({$urandom, $urandom, $urandom, $urandom}, 1'(w));
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    check("alt_count", W'(n_pop - pop0), W'(20));

    // Reset with two words in flight
    out_ready = 1'b0;
    send(128'h11111111222222223333333344444444, 1'b0);
    send(128'h55555555666666667777777788888888, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(0));
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", W'(in_ready), W'(1));
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("no_stale_output", W'(out_valid), W'(0));
    end
    idle(1);
    send(V1_IN, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule
